// File: rtl/fu_wb_arbiter_if.sv
// Bundle between the functional units, the arbiter and the register-file
// write port. The arbiter is the slave; the FU/control side is the master.
interface fu_wb_arbiter_if #(
  parameter int N_FU = 5,
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic [N_FU-1:0]      fu_finish;
  logic [N_FU*RD_W-1:0] fu_rd;
  logic [N_FU*XLEN-1:0] fu_data;
  logic                 flush;
  logic [N_FU-1:0]      fu_busy;
  logic                 wb_we;
  logic [RD_W-1:0]      wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic [N_FU-1:0]      wb_grant;
  logic [2:0]           pending_cnt;
  logic                 ovf_err;

  modport slave (
    input  fu_finish, fu_rd, fu_data, flush,
    output fu_busy, wb_we, wb_rd, wb_data, wb_grant, pending_cnt, ovf_err
  );

  modport master (
    output fu_finish, fu_rd, fu_data, flush,
    input  fu_busy, wb_we, wb_rd, wb_data, wb_grant, pending_cnt, ovf_err
  );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: each FU result lands in its own holding slot, and one
// slot per cycle is granted round-robin onto the single register write port.
module fu_wb_arbiter #(
  parameter int N_FU = 5,
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input logic            clk,
  input logic            rst,
  fu_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0]  valid_q, valid_d;
  logic [RD_W-1:0]  rd_q   [N_FU];
  logic [RD_W-1:0]  rd_d   [N_FU];
  logic [XLEN-1:0]  data_q [N_FU];
  logic [XLEN-1:0]  data_d [N_FU];
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             ovf_q, ovf_d;

  logic             found_s;
  logic [PTR_W-1:0] gnt_idx_s;
  logic [N_FU-1:0]  grant_s;
  logic [N_FU-1:0]  busy_s;

  // (base + k) wrapped into 0..N_FU-1; k never exceeds N_FU-1 here.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_FU) begin
      sum = sum - N_FU;
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  // Number of set bits in the slot-valid vector.
  function automatic logic [2:0] popcount(input logic [N_FU-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < N_FU; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

  // Round-robin search: first valid slot at or after rr_ptr, wrapping.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    for (int k = 0; k < N_FU; k++) begin
      if (!found_s && valid_q[wrap_idx(rr_ptr_q, k)]) begin
        found_s   = 1'b1;
        gnt_idx_s = wrap_idx(rr_ptr_q, k);
      end else begin
        found_s   = found_s;
      end
    end
    grant_s = '0;
    if (found_s) begin
      grant_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_s = grant_s;
    end
    busy_s = valid_q & ~grant_s;
  end

  // Drive the register write port from the granted slot (zeros when idle).
  always_comb begin
    bus.wb_grant    = grant_s;
    bus.fu_busy     = busy_s;
    bus.pending_cnt = popcount(valid_q);
    bus.ovf_err     = ovf_q;
    if (found_s) begin
      bus.wb_rd   = rd_q[gnt_idx_s];
      bus.wb_data = data_q[gnt_idx_s];
      bus.wb_we   = (rd_q[gnt_idx_s] != '0);
    end else begin
      bus.wb_rd   = '0;
      bus.wb_data = '0;
      bus.wb_we   = 1'b0;
    end
  end

  // Next state: retire the granted slot, then capture (capture wins on the
  // same slot), then flush wipes every slot including this cycle's captures.
  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    ovf_d    = ovf_q;
    if (found_s) begin
      valid_d[gnt_idx_s] = 1'b0;
      rr_ptr_d           = wrap_idx(gnt_idx_s, 1);
    end else begin
      rr_ptr_d           = rr_ptr_q;
    end
    for (int i = 0; i < N_FU; i++) begin
      if (!bus.flush && bus.fu_finish[i]) begin
        valid_d[i] = 1'b1;
        rd_d[i]    = bus.fu_rd[i*RD_W +: RD_W];
        data_d[i]  = bus.fu_data[i*XLEN +: XLEN];
        if (busy_s[i]) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_d;
        end
      end else begin
        valid_d[i] = valid_d[i];
      end
    end
    if (bus.flush) begin
      valid_d = '0;
    end else begin
      valid_d = valid_d;
    end
  end

  // State registers; reset drops every pending write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      rd_q     <= '{default: '0};
      data_q   <= '{default: '0};
      rr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule
